// File: rtl/vc_test_rand_delay_mem_nports.sv
// N-port test memory: every port answers after its own pseudo-random delay,
// drawn from a per-port LFSR and bounded by max_delay.
module vc_test_rand_delay_mem_nports #(
   parameter int          p_num_ports    = 2,
   parameter int          p_mem_nbytes   = 16384,
   parameter int          p_opaque_nbits = 8,
   parameter int          p_addr_nbits   = 32,
   parameter int          p_data_nbits   = 32,
   parameter logic [15:0] p_seed         = 16'hACE1,
   localparam int c_b  = p_data_nbits / 8,
   localparam int c_l  = $clog2(c_b),
   localparam int c_rq = 3 + p_opaque_nbits + p_addr_nbits + c_l + p_data_nbits,
   localparam int c_rs = 3 + p_opaque_nbits + 2 + c_l + p_data_nbits
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mem_clear,
   input  logic [7:0]                  max_delay,
   input  logic [p_num_ports-1:0]      memreq_val,
   output logic [p_num_ports-1:0]      memreq_rdy,
   input  logic [p_num_ports*c_rq-1:0] memreq_msg,
   output logic [p_num_ports-1:0]      memresp_val,
   input  logic [p_num_ports-1:0]      memresp_rdy,
   output logic [p_num_ports*c_rs-1:0] memresp_msg
);

   localparam int c_lo_len  = p_data_nbits;
   localparam int c_lo_addr = c_lo_len + c_l;
   localparam int c_lo_opq  = c_lo_addr + p_addr_nbits;
   localparam int c_lo_type = c_lo_opq + p_opaque_nbits;
   localparam int c_mbits   = $clog2(p_mem_nbytes);
   localparam int c_iw      = c_mbits - c_l;
   localparam int c_nwords  = p_mem_nbytes / c_b;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RESP} state_t;

   state_t                  r_state     [p_num_ports];
   state_t                  w_state_nxt [p_num_ports];
   logic [7:0]              r_cnt       [p_num_ports];
   logic [7:0]              w_cnt_nxt   [p_num_ports];
   logic [7:0]              w_draw      [p_num_ports];
   logic [15:0]             r_lfsr      [p_num_ports];
   logic [c_rq-1:0]         r_req       [p_num_ports];
   logic [c_rq-1:0]         w_areq      [p_num_ports];
   logic [p_data_nbits-1:0] r_rdata     [p_num_ports];
   logic [p_data_nbits-1:0] w_rdata     [p_num_ports];
   logic [c_iw-1:0]         w_idx       [p_num_ports];
   int                      w_off       [p_num_ports];
   int                      w_nb        [p_num_ports];
   logic [p_num_ports-1:0]  w_hs;
   logic [p_num_ports-1:0]  w_acc;
   logic [p_data_nbits-1:0] r_mem       [c_nwords];

   function automatic logic [15:0] f_seed(input int i);
      logic [15:0] s;
      s = p_seed ^ 16'(i + 1);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic int f_nbytes(input logic [c_l-1:0] len);
      return (len == '0) ? c_b : int'(len);
   endfunction

   // Lanes o.. shifted down to byte 0; lanes past the word boundary read as zero.
   function automatic logic [p_data_nbits-1:0] f_extract(input logic [p_data_nbits-1:0] word,
                                                         input int o, input int n);
      logic [p_data_nbits-1:0] res;
      res = '0;
      for (int j = 0; j < c_b; j++)
         if (j < n && o + j < c_b) res[8*j +: 8] = word[8*(o+j) +: 8];
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < p_num_ports; i++) begin
         w_hs[i]        = memreq_val[i] & reset & (r_state[i] == S_IDLE);
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_acc[i]       = 1'b0;
         w_areq[i]      = r_req[i];
         w_draw[i]      = 8'(r_lfsr[i] % (16'(max_delay) + 16'd1));
         case (r_state[i])
            S_IDLE: begin
               if (w_hs[i]) begin
                  w_areq[i]    = memreq_msg[i*c_rq +: c_rq];
                  w_cnt_nxt[i] = w_draw[i];
                  if (w_draw[i] == 8'd0) begin
                     w_acc[i]       = 1'b1;
                     w_state_nxt[i] = S_RESP;
                  end else begin
                     w_state_nxt[i] = S_DELAY;
                  end
               end
            end
            S_DELAY: begin
               w_cnt_nxt[i] = r_cnt[i] - 8'd1;
               if (r_cnt[i] == 8'd1) begin
                  w_acc[i]       = 1'b1;
                  w_state_nxt[i] = S_RESP;
               end
            end
            S_RESP: begin
               if (memresp_rdy[i]) w_state_nxt[i] = S_IDLE;
            end
            default: w_state_nxt[i] = S_IDLE;
         endcase
         w_off[i]   = int'(w_areq[i][c_lo_addr +: c_l]);
         w_nb[i]    = f_nbytes(w_areq[i][c_lo_len +: c_l]);
         w_idx[i]   = w_areq[i][c_lo_addr + c_l +: c_iw];
         w_rdata[i] = (w_areq[i][c_lo_type +: 3] == 3'd0) ?
                      f_extract(r_mem[w_idx[i]], w_off[i], w_nb[i]) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < p_num_ports; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= 8'd0;
            r_lfsr[i]  <= f_seed(i);
         end
      end else begin
         for (int i = 0; i < p_num_ports; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
            r_lfsr[i]  <= f_lfsr_next(r_lfsr[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < p_num_ports; i++) begin
         if (w_hs[i])  r_req[i]   <= memreq_msg[i*c_rq +: c_rq];
         if (w_acc[i]) r_rdata[i] <= w_rdata[i];
      end
   end

   // Later ports overwrite earlier ones on the same byte; clear beats every write.
   always_ff @(posedge clk) begin
      if (mem_clear) begin
         for (int w = 0; w < c_nwords; w++) r_mem[w] <= '0;
      end else begin
         for (int i = 0; i < p_num_ports; i++) begin
            if (w_acc[i] && w_areq[i][c_lo_type +: 3] == 3'd1) begin
               for (int b = 0; b < c_b; b++) begin
                  if (b >= w_off[i] && b < w_off[i] + w_nb[i])
                     r_mem[w_idx[i]][8*b +: 8] <= w_areq[i][8*(b - w_off[i]) +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      memreq_rdy  = '0;
      memresp_val = '0;
      memresp_msg = '0;
      for (int i = 0; i < p_num_ports; i++) begin
         memreq_rdy[i] = reset && (r_state[i] == S_IDLE);
         if (r_state[i] == S_RESP) begin
            memresp_val[i] = 1'b1;
            memresp_msg[i*c_rs +: c_rs] = {r_req[i][c_lo_type +: 3],
                                           r_req[i][c_lo_opq +: p_opaque_nbits],
                                           2'b00,
                                           r_req[i][c_lo_len +: c_l],
                                           r_rdata[i]};
         end
      end
   end

endmodule

// File: tb/tb_vc_test_rand_delay_mem_nports.sv
// Bench for the N-port random-delay test memory: directed vectors on three
// ports plus a long per-port traffic run against a byte-level reference.
module tb_vc_test_rand_delay_mem_nports;

   localparam int NP   = 3;
   localparam int RQ   = 77;
   localparam int RS   = 47;
   localparam int NOPS = 1000;

   logic             clk = 1'b0;
   logic             reset;
   logic             mem_clear;
   logic [7:0]       max_delay;
   logic [NP-1:0]    memreq_val;
   logic [NP-1:0]    memreq_rdy;
   logic [NP*RQ-1:0] memreq_msg;
   logic [NP-1:0]    memresp_val;
   logic [NP-1:0]    memresp_rdy;
   logic [NP*RS-1:0] memresp_msg;

   logic             t_val  [NP];
   logic             t_rrdy [NP];
   logic [RQ-1:0]    t_msg  [NP];
   logic [15:0]      m_lfsr [NP];
   logic [7:0]       m_mem  [16384];
   int               n_tot = 0;
   int               n_bad = 0;

   always #5 clk = ~clk;

   vc_test_rand_delay_mem_nports #(.p_num_ports(NP)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_clear   (mem_clear),
      .max_delay   (max_delay),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memreq_msg  (memreq_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .memresp_msg (memresp_msg)
   );

   always_comb begin
      for (int i = 0; i < NP; i++) begin
         memreq_val[i]           = t_val[i];
         memresp_rdy[i]          = t_rrdy[i];
         memreq_msg[i*RQ +: RQ]  = t_msg[i];
      end
   end

   // Reference LFSRs: seed ^ (port+1), taps 16,14,13,11, one step per clock.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NP; i++) m_lfsr[i] <= 16'hACE1 ^ 16'(i + 1);
      end else begin
         for (int i = 0; i < NP; i++)
            m_lfsr[i] <= {m_lfsr[i][14:0],
                          m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tot++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] ref_access(input logic [2:0] t, input logic [31:0] a,
                                              input logic [1:0] ln, input logic [31:0] d);
      int base, o, n;
      logic [31:0] r;
      base = int'({a[13:2], 2'b00});
      o    = int'(a[1:0]);
      n    = (ln == 2'd0) ? 4 : int'(ln);
      r    = '0;
      for (int k = 0; k < n && o + k < 4; k++) begin
         if (t == 3'd1)      m_mem[base+o+k] = d[8*k +: 8];
         else if (t == 3'd0) r[8*k +: 8]     = m_mem[base+o+k];
      end
      return r;
   endfunction

   task automatic run_op(input int p, input logic [2:0] t, input logic [31:0] a,
                         input logic [1:0] ln, input logic [31:0] d, input logic [7:0] op,
                         input logic [31:0] exp_data, input bit clr, input int stall,
                         input string tag);
      logic [RS-1:0] exp_msg;
      int guard, lat, exp_lat;
      exp_msg = {t, op, 2'b00, ln, exp_data};
      @(negedge clk);
      t_msg[p] = {t, op, a, ln, d};
      t_val[p] = 1'b1;
      guard = 0;
      while (!memreq_rdy[p] && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_rdy"}, 64'(memreq_rdy[p]), 64'd1);
      exp_lat = 1 + int'(m_lfsr[p] % (16'(max_delay) + 16'd1));
      if (clr) mem_clear = 1'b1;
      @(negedge clk);
      t_val[p] = 1'b0;
      if (clr) mem_clear = 1'b0;
      lat = 1;
      while (!memresp_val[p] && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      for (int s = 0; s < stall; s++) begin
         chk({tag, "_hold"}, 64'(memresp_msg[p*RS +: RS]), 64'(exp_msg));
         @(negedge clk);
      end
      chk({tag, "_msg"}, 64'(memresp_msg[p*RS +: RS]), 64'(exp_msg));
      t_rrdy[p] = 1'b1;
      @(negedge clk);
      t_rrdy[p] = 1'b0;
   endtask

   // Each port owns a 4 KB region so the reference stays order-independent across ports.
   task automatic rand_port(input int p);
      logic [2:0]  t;
      logic [31:0] a, d, e;
      logic [1:0]  ln;
      int r, st;
      for (int k = 0; k < NOPS; k++) begin
         r  = int'($urandom_range(0, 9));
         t  = (r < 4) ? 3'd1 : (r < 9) ? 3'd0 : 3'd2;
         a  = 32'(p * 32'h1000 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a[20] = 1'b1;
         ln = 2'($urandom_range(0, 3));
         d  = $urandom;
         st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         e  = ref_access(t, a, ln, d);
         run_op(p, t, a, ln, d, 8'(k), e, 1'b0, st, "rnd");
      end
   endtask

   initial begin
      int guard;
      reset = 1'b0; mem_clear = 1'b0; max_delay = 8'd0;
      for (int i = 0; i < NP; i++) begin
         t_val[i] = 1'b0; t_rrdy[i] = 1'b0; t_msg[i] = '0;
      end
      for (int w = 0; w < 16384; w++) m_mem[w] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_reqrdy", 64'(memreq_rdy), 64'd0);
      chk("rst_respval", 64'(memresp_val), 64'd0);
      for (int i = 0; i < NP; i++) chk("rst_msg", 64'(memresp_msg[i*RS +: RS]), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_reqrdy", 64'(memreq_rdy), 64'h7);
      mem_clear = 1'b1;
      @(negedge clk);
      mem_clear = 1'b0;

      run_op(0, 3'd1, 32'h100, 2'd0, 32'hDEADBEEF, 8'h11, 32'h0, 1'b0, 0, "wr100");
      run_op(0, 3'd0, 32'h100, 2'd0, 32'h0, 8'h12, 32'hDEADBEEF, 1'b0, 2, "rd100");
      run_op(2, 3'd0, 32'h00104100, 2'd0, 32'h0, 8'h13, 32'hDEADBEEF, 1'b0, 0, "rdwrap");
      run_op(1, 3'd1, 32'h203, 2'd1, 32'h000000AB, 8'h21, 32'h0, 1'b0, 0, "wr203");
      run_op(1, 3'd0, 32'h200, 2'd0, 32'h0, 8'h22, 32'hAB000000, 1'b0, 0, "rd200");
      run_op(1, 3'd0, 32'h202, 2'd0, 32'h0, 8'h23, 32'h0000AB00, 1'b0, 0, "rd202");
      run_op(0, 3'd2, 32'h100, 2'd0, 32'h0, 8'h24, 32'h0, 1'b0, 0, "othertype");

      run_op(0, 3'd1, 32'h40, 2'd0, 32'h5A5A5A5A, 8'h30, 32'h0, 1'b0, 0, "wr40pre");
      fork
         run_op(0, 3'd1, 32'h40, 2'd0, 32'h11111111, 8'h31, 32'h0, 1'b0, 0, "same_w0");
         run_op(1, 3'd1, 32'h40, 2'd0, 32'h22222222, 8'h32, 32'h0, 1'b0, 0, "same_w1");
         run_op(2, 3'd0, 32'h40, 2'd0, 32'h0, 8'h33, 32'h5A5A5A5A, 1'b0, 0, "same_rd");
      join
      run_op(2, 3'd0, 32'h40, 2'd0, 32'h0, 8'h34, 32'h22222222, 1'b0, 0, "rd40");

      run_op(0, 3'd1, 32'h80, 2'd0, 32'hCAFEF00D, 8'h40, 32'h0, 1'b0, 0, "wr80pre");
      fork
         run_op(0, 3'd1, 32'h80, 2'd0, 32'h12345678, 8'h41, 32'h0, 1'b1, 0, "clr_wr");
         run_op(1, 3'd0, 32'h80, 2'd0, 32'h0, 8'h42, 32'hCAFEF00D, 1'b0, 0, "clr_rd");
      join
      run_op(1, 3'd0, 32'h80, 2'd0, 32'h0, 8'h43, 32'h0, 1'b0, 0, "rd80");
      run_op(2, 3'd0, 32'h100, 2'd0, 32'h0, 8'h44, 32'h0, 1'b0, 0, "rd100clr");

      // Reset while port 0 waits out a delay of at least three cycles.
      max_delay = 8'd10;
      @(negedge clk);
      guard = 0;
      while ((m_lfsr[0] % 16'd11) < 16'd3 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      t_msg[0] = {3'd1, 8'h55, 32'h300, 2'd0, 32'h77777777};
      t_val[0] = 1'b1;
      @(negedge clk);
      t_val[0] = 1'b0;
      chk("dly_busy", 64'(memreq_rdy[0]), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_reqrdy", 64'(memreq_rdy), 64'd0);
      chk("midrst_respval", 64'(memresp_val), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrel_reqrdy", 64'(memreq_rdy), 64'h7);
      repeat (12) @(negedge clk);
      chk("midrel_noresp", 64'(memresp_val), 64'd0);
      max_delay = 8'd0;
      run_op(0, 3'd0, 32'h300, 2'd0, 32'h0, 8'h56, 32'h0, 1'b0, 0, "rd300");

      mem_clear = 1'b1;
      @(negedge clk);
      mem_clear = 1'b0;
      for (int w = 0; w < 16384; w++) m_mem[w] = 8'h00;
      max_delay = 8'd20;
      fork
         rand_port(0);
         rand_port(1);
         rand_port(2);
      join

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vc_test_rand_delay_mem_nports.md
Name: vc_test_rand_delay_mem_nports

Overview:
- Parametrised N-port test memory with independent per-port random response delay.
- Generalises the current fixed two-port, 4-byte test memory to any port count, data width and seed.
- Used in processor and cache benches. Typical wiring: port 0 to imem, port 1 to dmem, further ports to extra cores or DMA.
- Synthesisable control; the storage array is a plain register array.

Parameters:
- p_num_ports, 2: number of independent request/response port pairs (1..8).
- p_mem_nbytes, 16384: memory size in bytes; power of two.
- p_opaque_nbits, 8: opaque field width.
- p_addr_nbits, 32: address width (byte address).
- p_data_nbits, 32: data width; 32 or 64. Define B = p_data_nbits/8 and L = log2(B).
- p_seed, 16'hACE1: base LFSR seed. Port i is seeded with p_seed XOR (i+1); a seed of zero is replaced by 16'h0001.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_clear  in  1  synchronous; zeroes the whole array at the next rising edge.
- max_delay  in  8  upper bound of the random delay, inclusive.
- memreq_val  in  p_num_ports  request valid, one bit per port.
- memreq_rdy  out  p_num_ports  request ready, one bit per port.
- memreq_msg  in  p_num_ports*RQ  requests. RQ = 3+p_opaque_nbits+p_addr_nbits+L+p_data_nbits. Fields MSB→LSB: type, opaque, addr, len, data. Port i occupies slice [i*RQ +: RQ].
- memresp_val  out  p_num_ports  response valid.
- memresp_rdy  in  p_num_ports  response ready.
- memresp_msg  out  p_num_ports*RS  responses. RS = 3+p_opaque_nbits+2+L+p_data_nbits. Fields MSB→LSB: type, opaque, test(2'b0), len, data.

Behaviour:
- Per-port FSM, IDLE/DELAY/RESP. All ports are identical and independent except for array conflicts.
- Reset (reset=0, asynchronous):
  - every FSM goes to IDLE; memreq_rdy=0 while in reset, then all 1s in the first cycle after release;
  - memresp_val=0; memresp_msg=0;
  - LFSRs reload their seeds;
  - array contents are untouched.
- IDLE:
  - memreq_rdy[i]=1.
  - On val&rdy: latch the request; load counter with d = lfsr_i mod (max_delay+1).
  - d=0: perform the access at this edge and go to RESP.
  - d>0: go to DELAY.
- DELAY:
  - memreq_rdy=0; counter decrements each edge.
  - Access is performed on the edge where the counter is 1, then go to RESP.
- RESP:
  - memresp_val=1; msg held stable until memresp_rdy.
  - On handshake go to IDLE. A new request is not accepted in the same cycle.
- Latency: accept at edge k, response valid from edge k+1+d. Minimum one cycle; back-to-back throughput is one request per two cycles per port.
- LFSRs:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Each advances every cycle regardless of traffic; the draw uses the value present at the acceptance edge.
- Access rules:
  - word index = addr[log2(p_mem_nbytes)-1:L]; higher address bits are ignored (wrap).
  - byte offset o = addr[L-1:0]; nbytes n = (len==0) ? B : len.
  - Bytes o..min(o+n,B)-1 are accessed; bytes past the word boundary are dropped (no wrap).
  - Write (type 1): data bytes 0..n-1 go to lanes o.. of the word; resp data=0.
  - Read (type 0): resp data = lanes o.. shifted down to byte 0, zero-extended.
  - Other types: no array effect, resp data=0, type echoed.
  - Response opaque, type and len are copied from the request.
- Same-edge conflicts:
  - Reads return pre-edge array contents.
  - Multiple writes to the same byte: the highest port index wins.
  - mem_clear overrides all writes on that edge. Reads on that edge still return pre-clear data.
- Reset mid-DELAY or mid-RESP: the transaction is dropped with no response. An access already performed stays in the array.
- max_delay changes take effect only for subsequently accepted requests.

Test Plan:
- Port 0, max_delay=0, write addr 0x100 data 0xDEADBEEF len 0, then read 0x100 → resp valid exactly 1 cycle after each accept; read data 0xDEADBEEF, opaque echoed.
- Port 1 sub-word: write 0x203 len 1 data 0xAB, then read 0x200 len 0 → 0xAB000000. Read 0x202 len 0 → 0x0000AB00; bytes past the word boundary are dropped.
- Same edge, max_delay=0: ports 0 and 1 both write 0x40 (0x11111111 and 0x22222222) and port 2 reads 0x40 → read returns the old value; a later read returns 0x22222222.
- max_delay=20, 1000 random ops per port with memresp_rdy randomly stalled → responses in order per port, every delay within 0..20, data matches the reference model, msg stable while stalled.
- Assert reset low while port 0 is in DELAY with a pending write → no response, rdy=1 after release, written word unchanged if the access had not yet occurred.
- Pulse mem_clear on the same edge as a write to 0x80 → a read of 0x80 returns 0.
